uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO feeding an 8N1/8N2 UART transmitter whose baud ticks
//             come from a 20-bit phase accumulator. Frames are sent
//             back-to-back while the FIFO holds data.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    // round(2^19 * BAUD / CLK_FREQ) done in integer arithmetic
    localparam longint c_INC_WIDE =
        ((longint'(BAUD) <<< 20) + longint'(CLK_FREQ)) / (longint'(CLK_FREQ) * 2);
    localparam logic [19:0]     c_INC       = c_INC_WIDE[19:0];
    localparam logic            c_LAST_STOP = (STOP_BITS == 2);
    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(FIFO_DEPTH);

    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [19:0]       acc_q, acc_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_q, tx_d;
    logic [c_PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_CW-1:0]   count_q, count_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic              tick;
    logic              final_stop;

    assign wr_ready   = (count_q < c_DEPTH);
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign tx         = tx_q;

    // Next-state, baud accumulator, shifter and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        acc_d      = {1'b0, acc_q[18:0]} + c_INC;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        push       = resetn && wr_valid && wr_ready;
        tick       = acc_q[19];
        final_stop = (state_q == S_STOP) && tick && (stop_cnt_q == c_LAST_STOP);
        pop        = (count_q != '0) && ((state_q == S_IDLE) || final_stop);

        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                if (pop) begin
                    state_d = S_START;
                    acc_d   = c_INC;   // full first bit period
                    shift_d = mem_q[rd_ptr_q];
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = S_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            S_STOP: begin
                if (final_stop) begin
                    if (pop) begin
                        state_d = S_START;
                        acc_d   = c_INC;
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                    end
                end else if (tick) begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state one cycle later
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Scoreboard bench for uart_tx_fifo; two instances (1 and 2 stop
//             bits), serial receivers pop expected bytes from queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_valid1, wr_valid2;
    logic [7:0] wr_data1, wr_data2;
    logic       wr_ready1, wr_ready2;
    logic       tx1, tx2;
    logic       busy1, busy2;
    logic [4:0] cnt1, cnt2;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] exp1[$];
    logic [7:0] exp2[$];
    int         starts1[$];
    logic       track = 1'b0;
    int         maxc  = 0;

    uart_tx_fifo #(.CLK_FREQ(1843200), .BAUD(115200), .FIFO_DEPTH(16), .STOP_BITS(1)) dut1 (
        .clk(clk), .resetn(resetn), .wr_valid(wr_valid1), .wr_data(wr_data1),
        .wr_ready(wr_ready1), .tx(tx1), .busy(busy1), .fifo_count(cnt1));

    uart_tx_fifo #(.CLK_FREQ(1843200), .BAUD(115200), .FIFO_DEPTH(16), .STOP_BITS(2)) dut2 (
        .clk(clk), .resetn(resetn), .wr_valid(wr_valid2), .wr_data(wr_data2),
        .wr_ready(wr_ready2), .tx(tx2), .busy(busy2), .fifo_count(cnt2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (track && (int'(cnt1) > maxc)) maxc = int'(cnt1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic line_of(input int w);
        return (w == 1) ? tx1 : tx2;
    endfunction

    // Serial receiver: samples mid-bit, compares against the expected queue
    task automatic monitor(input int w);
        logic [7:0] b;
        logic       aborted, st, stp;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && line_of(w) === 1'b0) begin
                if (w == 1) starts1.push_back(cyc);
                aborted = 1'b0;
                stp     = 1'b1;
                repeat (8) begin @(negedge clk); if (!resetn) aborted = 1'b1; end
                st = line_of(w);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) begin @(negedge clk); if (!resetn) aborted = 1'b1; end
                    b[i] = line_of(w);
                end
                for (int s = 0; s < w; s++) begin
                    repeat (16) begin @(negedge clk); if (!resetn) aborted = 1'b1; end
                    stp = stp & line_of(w);
                end
                if (!aborted) begin
                    check($sformatf("start_bit%0d", w), st, 1'b0);
                    check($sformatf("stop_bits%0d", w), stp, 1'b1);
                    if (w == 1) begin
                        if (exp1.size() == 0) check("unexpected_frame1", b, 32'hFFFF_FFFF);
                        else check("byte1", b, exp1.pop_front());
                    end else begin
                        if (exp2.size() == 0) check("unexpected_frame2", b, 32'hFFFF_FFFF);
                        else check("byte2", b, exp2.pop_front());
                    end
                end
            end
        end
    endtask

    initial monitor(1);
    initial monitor(2);

    // Offer a byte, hold until accepted; expected byte queued on acceptance
    task automatic send(input int w, input logic [7:0] b);
        logic rdy;
        int   t;
        t   = 0;
        rdy = 1'b0;
        @(negedge clk);
        while (!rdy && t < 2000) begin
            if (w == 1) begin wr_valid1 = 1'b1; wr_data1 = b; rdy = wr_ready1; end
            else        begin wr_valid2 = 1'b1; wr_data2 = b; rdy = wr_ready2; end
            @(posedge clk);
            if (!rdy) begin t++; @(negedge clk); end
        end
        #1;
        wr_valid1 = 1'b0;
        wr_valid2 = 1'b0;
        if (rdy) begin
            if (w == 1) exp1.push_back(b); else exp2.push_back(b);
        end else begin
            check("send_timeout", 1'b0, 1'b1);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp1.size() != 0 || exp2.size() != 0 || busy1 || busy2) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", (t < 4000), 1'b1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, lowcnt;
        resetn = 1'b0; wr_valid1 = 1'b0; wr_valid2 = 1'b0; wr_data1 = '0; wr_data2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx1, 1'b1);
        check("rst_busy", busy1, 1'b0);
        check("rst_wr_ready", wr_ready1, 1'b1);
        check("rst_count", cnt1, 5'd0);
        check("rst_tx2", tx2, 1'b1);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55: 2-cycle latency, busy length
        send(1, 8'h55);
        @(negedge clk);
        check("t1_count_after_push", cnt1, 5'd1);
        check("t1_tx_n1", tx1, 1'b1);
        @(negedge clk);
        check("t1_count_after_pop", cnt1, 5'd0);
        check("t1_tx_n2", tx1, 1'b1);
        @(negedge clk);
        check("t1_tx_start_low", tx1, 1'b0);
        repeat (158) @(negedge clk);
        check("t1_busy_last", busy1, 1'b1);
        @(negedge clk);
        check("t1_busy_dropped", busy1, 1'b0);
        drain();

        // 0x00 then 0xFF in consecutive cycles: contiguous frames
        starts1.delete();
        send(1, 8'h00);
        send(1, 8'hFF);
        @(negedge clk);
        check("t2_count_push_pop", cnt1, 5'd1);
        repeat (159) @(negedge clk);
        check("t2_count_before_pop", cnt1, 5'd1);
        @(negedge clk);
        check("t2_count_after_pop", cnt1, 5'd0);
        drain();
        check("t2_frames", starts1.size(), 2);
        if (starts1.size() == 2) check("t2_gap", starts1[1] - starts1[0], 160);

        // Fill the FIFO, then one more byte must stall until space opens
        for (int i = 0; i < 17; i++) send(1, 8'(8'h10 + i * 7));
        @(negedge clk);
        check("t3_wr_ready_full", wr_ready1, 1'b0);
        check("t3_count_full", cnt1, 5'd16);
        c0 = cyc;
        send(1, 8'hE7);
        check("t3_stalled", (cyc - c0) > 20, 1'b1);
        drain();

        // Two stop bits: 11-bit frame of 176 clocks
        send(2, 8'hA5);
        repeat (177) @(negedge clk);
        check("t4_busy_last", busy2, 1'b1);
        @(negedge clk);
        check("t4_busy_dropped", busy2, 1'b0);
        drain();

        // Reset mid-frame with 3 bytes queued
        send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44);
        repeat (47) @(negedge clk);
        resetn = 1'b0; wr_valid1 = 1'b1; wr_data1 = 8'h99;
        @(negedge clk);
        check("t5_tx", tx1, 1'b1);
        check("t5_count", cnt1, 5'd0);
        check("t5_busy", busy1, 1'b0);
        check("t5_wr_ready", wr_ready1, 1'b1);
        exp1.delete();
        @(negedge clk);
        resetn = 1'b1; wr_valid1 = 1'b0;
        lowcnt = 0;
        repeat (400) begin @(negedge clk); if (tx1 !== 1'b1) lowcnt++; end
        check("t5_quiet_line", lowcnt, 0);
        check("t5_count_after", cnt1, 5'd0);
        drain();

        // Push exactly on the final stop tick with one byte queued
        maxc = 0; track = 1'b1;
        send(1, 8'h3C);
        send(1, 8'hC3);
        repeat (159) @(posedge clk);
        send(1, 8'h5A);
        @(negedge clk);
        check("t6_count_on_tick", cnt1, 5'd1);
        drain();
        track = 1'b0;
        check("t6_max_count", maxc, 1);

        check("exp1_empty", exp1.size(), 0);
        check("exp2_empty", exp2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
